// File: rtl/soc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// soc_mem_arbiter
//    Shares one single-port 32-bit block RAM between two bus masters:
//    port 0 (CPU load/store/fetch) and port 1 (UART boot loader / debug writer).
//    Requests are serialised through a four-state FSM. The RAM sees one
//    registered access per grant. The winning master gets one ready pulse, and
//    read data is returned alongside that pulse.
//
//    Optional feature macro: ARB_RR_EN
//       defined   : round-robin on conflict (grant the port that was not served
//                   last; port 0 wins the first conflict after reset)
//       undefined : fixed priority, port 0 always wins a conflict
//
// Parameters
//    AW       word-address width of the shared RAM (2^AW x 32-bit words)
//    MEM_LAT  RAM read latency in cycles (1..3), counted from o_mem_en
//
// Ports
//    i_clk          system clock, rising edge
//    i_rst_n        asynchronous active-low reset
//    i_m0_valid     port-0 request, held until o_m0_ready
//    i_m0_addr      port-0 word address
//    i_m0_wdata     port-0 write data
//    i_m0_wmask     port-0 byte write mask, 4'b0000 = read
//    o_m0_rdata     port-0 read data, valid while o_m0_ready=1, held otherwise
//    o_m0_ready     port-0 one-cycle completion pulse
//    i_m1_* / o_m1_* identical set for port 1
//    o_mem_en       RAM access strobe, one cycle per access
//    o_mem_addr     RAM word address (registered at grant)
//    o_mem_wdata    RAM write data (registered at grant)
//    o_mem_wmask    RAM byte enables, 0 whenever o_mem_en=0
//    i_mem_rdata    RAM read data, valid MEM_LAT cycles after o_mem_en
//    o_busy         high in any state other than IDLE
//
// State | Meaning
// ------+--------------------------------------------------------------
// IDLE  | no access in flight; grant a requester and latch its payload
// ISSUE | o_mem_en pulse; writes complete, reads start the latency timer
// WAIT  | count read latency down; capture i_mem_rdata at terminal count
// DONE  | one-cycle ready pulse to the winner; update last grant
// -----------------------------------------------------------------------------
module soc_mem_arbiter #(
   parameter int AW      = 14,
   parameter int MEM_LAT = 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,

   input  logic          i_m0_valid,
   input  logic [AW-1:0] i_m0_addr,
   input  logic [31:0]   i_m0_wdata,
   input  logic [3:0]    i_m0_wmask,
   output logic [31:0]   o_m0_rdata,
   output logic          o_m0_ready,

   input  logic          i_m1_valid,
   input  logic [AW-1:0] i_m1_addr,
   input  logic [31:0]   i_m1_wdata,
   input  logic [3:0]    i_m1_wmask,
   output logic [31:0]   o_m1_rdata,
   output logic          o_m1_ready,

   output logic          o_mem_en,
   output logic [AW-1:0] o_mem_addr,
   output logic [31:0]   o_mem_wdata,
   output logic [3:0]    o_mem_wmask,
   input  logic [31:0]   i_mem_rdata,

   output logic          o_busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Latency timer is a down-counter: loaded with MEM_LAT-1 in ISSUE, the read
   // data is captured in the WAIT cycle where it reaches zero.
   localparam int         CW       = 2;
   localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            r_winner;
   logic [AW-1:0]   r_mem_addr;
   logic [31:0]     r_mem_wdata;
   logic [3:0]      r_wmask;
   logic [31:0]     r_m0_rdata;
   logic [31:0]     r_m1_rdata;

   logic            w_any_req;
   logic            w_gnt_port;
   logic            w_grant;
   logic            w_capture;

   // -------------------------------------------------------------------------
   // Arbitration. A lone requester always wins; only a conflict consults the
   // policy.
   // -------------------------------------------------------------------------
   assign w_any_req = i_m0_valid | i_m1_valid;

`ifdef ARB_RR_EN
   logic r_last_grant;

   always_comb begin
      w_gnt_port = 1'b0;
      if (i_m0_valid && i_m1_valid) begin
         w_gnt_port = ~r_last_grant;
      end else if (i_m1_valid) begin
         w_gnt_port = 1'b1;
      end
   end

   // Resets to port 1 so that port 0 wins the first conflict.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last_grant <= 1'b1;
      end else if (r_state == S_DONE) begin
         r_last_grant <= r_winner;
      end
   end
`else
   // Fixed priority: port 1 is chosen only when port 0 is not requesting.
   always_comb begin
      w_gnt_port = 1'b0;
      if (!i_m0_valid && i_m1_valid) begin
         w_gnt_port = 1'b1;
      end
   end
`endif

   assign w_grant = (r_state == S_IDLE) && w_any_req;

   // -------------------------------------------------------------------------
   // FSM next-state and decoded outputs
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_capture   = 1'b0;
      o_mem_en    = 1'b0;
      o_m0_ready  = 1'b0;
      o_m1_ready  = 1'b0;
      o_busy      = 1'b1;

      case (r_state)
         S_IDLE: begin
            o_busy = 1'b0;
            if (w_any_req) begin
               w_state_nxt = S_ISSUE;
            end
         end

         S_ISSUE: begin
            o_mem_en = 1'b1;
            if (r_wmask == 4'b0000) begin
               w_cnt_nxt   = CNT_INIT;
               w_state_nxt = S_WAIT;
            end else begin
               w_state_nxt = S_DONE;
            end
         end

         S_WAIT: begin
            if (r_cnt == '0) begin
               w_capture   = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end

         S_DONE: begin
            o_m0_ready  = ~r_winner;
            o_m1_ready  = r_winner;
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State, payload latch and read-data capture
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_winner    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_wmask     <= '0;
         r_m0_rdata  <= '0;
         r_m1_rdata  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;

         // Payload is frozen here; the master may change its bus afterwards
         // without affecting the access in flight.
         if (w_grant) begin
            r_winner <= w_gnt_port;
            if (w_gnt_port) begin
               r_mem_addr  <= i_m1_addr;
               r_mem_wdata <= i_m1_wdata;
               r_wmask     <= i_m1_wmask;
            end else begin
               r_mem_addr  <= i_m0_addr;
               r_mem_wdata <= i_m0_wdata;
               r_wmask     <= i_m0_wmask;
            end
         end

         if (w_capture) begin
            if (r_winner) begin
               r_m1_rdata <= i_mem_rdata;
            end else begin
               r_m0_rdata <= i_mem_rdata;
            end
         end
      end
   end

   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   // The latched mask lingers after ISSUE; gate it so the RAM never sees
   // byte enables without a strobe.
   assign o_mem_wmask = o_mem_en ? r_wmask : 4'b0000;
   assign o_m0_rdata  = r_m0_rdata;
   assign o_m1_rdata  = r_m1_rdata;

endmodule
